// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO consecutive upstream FIFO words into one output beat,
// with flush support for emitting a partial beat and a sticky protocol error.
module fifo_rd_packer #(
  parameter int unsigned FIFO_WIDTH = 3,
  parameter int unsigned PACK_RATIO = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fifo_empty,
  output logic                                rd_en,
  input  logic                                rd_vld,
  input  logic [FIFO_WIDTH-1:0]               rd_data,
  input  logic                                flush,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [FIFO_WIDTH*PACK_RATIO-1:0]    out_data,
  output logic [$clog2(PACK_RATIO):0]         out_cnt,
  output logic                                flush_done,
  output logic                                err
);

  localparam int unsigned CW = $clog2(PACK_RATIO) + 1;
  localparam int unsigned DW = FIFO_WIDTH * PACK_RATIO;

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_HOLD} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_lane_cnt, w_lane_next;
  logic            r_inflight;
  logic            r_flush_pend, w_pend_next;
  logic            r_flush_beat, w_flush_beat_next;
  logic [DW-1:0]   r_acc, w_acc_next;
  logic [DW-1:0]   r_out_data, w_out_data_next;
  logic [CW-1:0]   r_out_cnt, w_out_cnt_next;
  logic            r_out_vld, w_out_vld_next;
  logic            r_flush_done, w_flush_done_next;
  logic            r_err;
  logic            w_take;
  logic            w_rd_en;

  // Issue a read only while filling with room for the word plus any read in flight.
  always_comb begin
    w_rd_en = rst && (r_state == S_FILL) && !fifo_empty && !r_flush_pend &&
              ((r_lane_cnt + CW'(r_inflight)) < CW'(PACK_RATIO));
  end

  // Next-state, lane accumulation and output beat formation.
  always_comb begin
    w_state_next      = r_state;
    w_lane_next       = r_lane_cnt;
    w_acc_next        = r_acc;
    w_out_data_next   = r_out_data;
    w_out_cnt_next    = r_out_cnt;
    w_out_vld_next    = r_out_vld;
    w_flush_done_next = 1'b0;
    w_pend_next       = r_flush_pend | flush;
    w_flush_beat_next = r_flush_beat;
    w_take            = rd_vld & r_inflight;

    if (w_take) begin
      for (int unsigned i = 0; i < PACK_RATIO; i++) begin
        if (r_lane_cnt == CW'(i)) begin
          w_acc_next[i*FIFO_WIDTH +: FIFO_WIDTH] = rd_data;
        end
      end
      w_lane_next = r_lane_cnt + CW'(1);
    end

    case (r_state)
      S_FILL, S_DRAIN: begin
        if (w_take && (r_lane_cnt == CW'(PACK_RATIO - 1))) begin
          w_out_data_next   = w_acc_next;
          w_out_cnt_next    = CW'(PACK_RATIO);
          w_out_vld_next    = 1'b1;
          w_lane_next       = '0;
          w_acc_next        = '0;
          w_flush_beat_next = 1'b0;
          w_state_next      = S_HOLD;
        end else if (r_flush_pend && !r_inflight) begin
          if (r_lane_cnt != '0) begin
            // Unused lanes are already zero since the accumulator is cleared per beat.
            w_out_data_next   = r_acc;
            w_out_cnt_next    = r_lane_cnt;
            w_out_vld_next    = 1'b1;
            w_lane_next       = '0;
            w_acc_next        = '0;
            w_flush_beat_next = 1'b1;
            w_state_next      = S_HOLD;
          end else begin
            w_flush_done_next = 1'b1;
            w_pend_next       = 1'b0;
            w_state_next      = S_FILL;
          end
        end else if (r_flush_pend) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_FILL;
        end
      end
      S_HOLD: begin
        if (out_rdy) begin
          w_out_vld_next = 1'b0;
          if (r_flush_beat) begin
            w_flush_done_next = 1'b1;
            w_pend_next       = 1'b0;
            w_flush_beat_next = 1'b0;
            w_state_next      = S_FILL;
          end else if (r_flush_pend) begin
            w_state_next = S_DRAIN;
          end else begin
            w_state_next = S_FILL;
          end
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  // State and datapath registers; reset drops partial word and in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FILL;
      r_lane_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_flush_beat <= 1'b0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_out_cnt    <= '0;
      r_out_vld    <= 1'b0;
      r_flush_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lane_cnt   <= w_lane_next;
      r_inflight   <= w_rd_en;
      r_flush_pend <= w_pend_next;
      r_flush_beat <= w_flush_beat_next;
      r_acc        <= w_acc_next;
      r_out_data   <= w_out_data_next;
      r_out_cnt    <= w_out_cnt_next;
      r_out_vld    <= w_out_vld_next;
      r_flush_done <= w_flush_done_next;
      r_err        <= r_err | (rd_vld & ~r_inflight);
    end
  end

  assign rd_en      = w_rd_en;
  assign out_vld    = r_out_vld;
  assign out_data   = r_out_data;
  assign out_cnt    = r_out_cnt;
  assign flush_done = r_flush_done;
  assign err        = r_err;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed cycle table plus FIFO-model sequences for fifo_rd_packer (3-bit words, 4 lanes).
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        rd_en;
  logic        rd_vld;
  logic [2:0]  rd_data;
  logic        flush;
  logic        out_vld;
  logic        out_rdy;
  logic [11:0] out_data;
  logic [2:0]  out_cnt;
  logic        flush_done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_recv   = 0;

  logic [2:0]  fifo_q[$];
  logic [11:0] exp_beats[$];
  logic [2:0]  grp[$];

  fifo_rd_packer #(.FIFO_WIDTH(3), .PACK_RATIO(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_en(rd_en),
    .rd_vld(rd_vld), .rd_data(rd_data), .flush(flush), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_cnt(out_cnt),
    .flush_done(flush_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        empty;
    logic        vld;
    logic [2:0]  data;
    logic        flsh;
    logic        rdy;
    logic        x_rd_en;
    logic        x_vld;
    logic [11:0] x_data;
    logic [2:0]  x_cnt;
    logic        x_fd;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(input logic e, input logic v, input logic [2:0] d,
                              input logic f, input logic r, input logic xr,
                              input logic xv, input logic [11:0] xd,
                              input logic [2:0] xc, input logic xf);
    vec_t t;
    t.empty = e; t.vld = v; t.data = d; t.flsh = f; t.rdy = r;
    t.x_rd_en = xr; t.x_vld = xv; t.x_data = xd; t.x_cnt = xc; t.x_fd = xf;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Queue a word into the FIFO model and build the expected full beats.
  task automatic push_word(input logic [2:0] w);
    fifo_q.push_back(w);
    grp.push_back(w);
    if (grp.size() == 4) begin
      exp_beats.push_back({grp[3], grp[2], grp[1], grp[0]});
      grp.delete();
    end
  endtask

  // One cycle with the FIFO model answering rd_en one cycle later; starts and ends at negedge.
  task automatic tick(input logic rdy, input logic gap);
    logic       do_rd;
    logic [2:0] w;
    w = 3'd0;
    flush      = 1'b0;
    out_rdy    = rdy;
    fifo_empty = gap || (fifo_q.size() == 0);
    #1;
    if (out_vld) begin
      if (exp_beats.size() == 0) begin
        chk("unexpected_beat", 32'(out_vld), 32'd0);
      end else begin
        chk("beat_data", 32'(out_data), 32'(exp_beats[0]));
        chk("beat_cnt", 32'(out_cnt), 32'd4);
      end
      chk("rd_en_in_hold", 32'(rd_en), 32'd0);
      if (out_rdy && exp_beats.size() != 0) begin
        void'(exp_beats.pop_front());
        n_recv++;
      end
    end
    do_rd = rd_en;
    if (do_rd) begin
      if (fifo_q.size() == 0) chk("rd_en_when_empty", 32'(fifo_empty), 32'd0);
      else w = fifo_q.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
    rd_vld  = do_rd;
    rd_data = w;
  endtask

  initial begin
    int target;

    // empty vld data flush rdy | rd_en out_vld out_data out_cnt flush_done
    vt[0]  = mk(0, 0, 3'd0, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[1]  = mk(0, 1, 3'd0, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[2]  = mk(0, 1, 3'd1, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[3]  = mk(0, 1, 3'd2, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[4]  = mk(1, 1, 3'd3, 0, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[5]  = mk(1, 0, 3'd0, 0, 1, 0, 1, 12'h688, 3'd4, 0);
    vt[6]  = mk(1, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[7]  = mk(0, 0, 3'd0, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[8]  = mk(0, 1, 3'd5, 0, 1, 1, 0, 12'h000, 3'd0, 0);
    vt[9]  = mk(1, 1, 3'd6, 1, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[10] = mk(1, 0, 3'd0, 0, 0, 0, 0, 12'h000, 3'd0, 0);
    vt[11] = mk(1, 0, 3'd0, 0, 0, 0, 1, 12'h035, 3'd2, 0);
    vt[12] = mk(1, 0, 3'd0, 0, 1, 0, 1, 12'h035, 3'd2, 0);
    vt[13] = mk(1, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 1);
    vt[14] = mk(1, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[15] = mk(1, 0, 3'd0, 1, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[16] = mk(0, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 0);
    vt[17] = mk(1, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 1);
    vt[18] = mk(1, 0, 3'd0, 0, 1, 0, 0, 12'h000, 3'd0, 0);

    rst = 1'b0; fifo_empty = 1'b0; rd_vld = 1'b0; rd_data = 3'd0;
    flush = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full beat 0,1,2,3; partial flush 5,6; empty flush.
    for (int i = 0; i < 19; i++) begin
      fifo_empty = vt[i].empty;
      rd_vld     = vt[i].vld;
      rd_data    = vt[i].data;
      flush      = vt[i].flsh;
      out_rdy    = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vt[i].x_rd_en));
      chk($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'(vt[i].x_vld));
      if (vt[i].x_vld) begin
        chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].x_data));
        chk($sformatf("vec%0d_out_cnt", i), 32'(out_cnt), 32'(vt[i].x_cnt));
      end
      chk($sformatf("vec%0d_flush_done", i), 32'(flush_done), 32'(vt[i].x_fd));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rd_vld = 1'b0; flush = 1'b0;

    // Eight words with back-pressure: first beat held, second beat after transfer.
    for (int i = 0; i < 8; i++) push_word(3'(7 - i));
    n_recv = 0;
    for (int c = 0; c < 15; c++) tick(1'b0, 1'b0);
    chk("bp_held_no_transfer", 32'(n_recv), 32'd0);
    for (int c = 0; c < 40 && n_recv < 2; c++) tick(1'b1, 1'b0);
    chk("bp_beats", 32'(n_recv), 32'd2);
    chk("bp_fifo_drained", 32'(fifo_q.size()), 32'd0);
    chk("bp_err", 32'(err), 32'd0);

    // 100 random words with random empty gaps and back-pressure.
    for (int i = 0; i < 100; i++) push_word(3'($urandom_range(0, 7)));
    n_recv = 0;
    target = 25;
    for (int c = 0; c < 3000 && n_recv < target; c++)
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    chk("rand_beats", 32'(n_recv), 32'(target));
    chk("rand_leftover", 32'(exp_beats.size()), 32'd0);
    chk("rand_err", 32'(err), 32'd0);

    // Reset mid-fill with two lanes filled and a read in flight.
    for (int i = 0; i < 4; i++) push_word(3'(i + 1));
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
    chk("mid_rd_vld_pending", 32'(rd_vld), 32'd1);
    rst = 1'b0;
    rd_vld = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("mid_rst_flush_done", 32'(flush_done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    fifo_q.delete(); exp_beats.delete(); grp.delete();
    fifo_empty = 1'b1;
    rst = 1'b1;
    rd_vld = 1'b1;
    rd_data = 3'd5;
    @(posedge clk);
    @(negedge clk);
    rd_vld = 1'b0;
    #1;
    chk("stray_err_set", 32'(err), 32'd1);
    chk("stray_no_beat", 32'(out_vld), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    chk("stray_err_sticky", 32'(err), 32'd1);
    chk("stray_no_beat_late", 32'(out_vld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
